// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage and IF/ID register with a one-entry skid buffer.
// Handles imem req/ack and branch / jump / jump-register redirects.
`default_nettype none

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] signeximmediate,
    input  logic [25:0] address,
    input  logic [31:0] jr_target
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] instruction_nxt, inst_pc_nxt;
    logic        inst_valid_nxt;
    logic [31:0] skid_data, skid_data_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic        kill, kill_nxt;

    logic        ack;
    logic        consumed;
    logic        redirect;
    logic [31:0] p4;
    logic [31:0] target;

    // Acks outside FETCH (e.g. a late one after reset) are ignored.
    assign ack      = imem_ack && (state == FETCH);
    assign consumed = inst_valid && !stall;
    assign redirect = consumed && (branch_taken || jump || jump_reg);
    assign p4       = inst_pc + 32'd4;

    always_comb begin
        target = p4 + (signeximmediate << 2);
        if (jump_reg)
            target = jr_target & ~32'h3;
        else if (jump)
            target = {p4[31:28], address, 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_addr    <= 32'd0;
            instruction <= 32'd0;
            inst_pc     <= 32'd0;
            inst_valid  <= 1'b0;
            skid_data   <= 32'd0;
            skid_pc     <= 32'd0;
            kill        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            req_addr    <= req_addr_nxt;
            instruction <= instruction_nxt;
            inst_pc     <= inst_pc_nxt;
            inst_valid  <= inst_valid_nxt;
            skid_data   <= skid_data_nxt;
            skid_pc     <= skid_pc_nxt;
            kill        <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        req_addr_nxt    = req_addr;
        instruction_nxt = instruction;
        inst_pc_nxt     = inst_pc;
        inst_valid_nxt  = inst_valid && !consumed;
        skid_data_nxt   = skid_data;
        skid_pc_nxt     = skid_pc;
        kill_nxt        = kill;

        case (state)
            IDLE: begin
                state_nxt    = FETCH;
                req_addr_nxt = pc;
            end
            FETCH: begin
                if (ack && kill) begin
                    // Squashed word: drop it, pc already holds the redirect target.
                    kill_nxt     = 1'b0;
                    req_addr_nxt = pc;
                end else if (ack && !redirect) begin
                    pc_nxt = pc + 32'd4;
                    if (!inst_valid || consumed) begin
                        instruction_nxt = imem_rdata;
                        inst_pc_nxt     = req_addr;
                        inst_valid_nxt  = 1'b1;
                        req_addr_nxt    = pc + 32'd4;
                    end else begin
                        skid_data_nxt = imem_rdata;
                        skid_pc_nxt   = req_addr;
                        state_nxt     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (consumed) begin
                    instruction_nxt = skid_data;
                    inst_pc_nxt     = skid_pc;
                    inst_valid_nxt  = 1'b1;
                    state_nxt       = FETCH;
                    req_addr_nxt    = pc;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A redirect squashes the slot and the skid; an outstanding request is
        // left untouched and its data is dropped via kill.
        if (redirect) begin
            pc_nxt         = target;
            inst_valid_nxt = 1'b0;
            if (state == DRAIN) begin
                state_nxt    = FETCH;
                req_addr_nxt = target;
            end else if (state == FETCH) begin
                if (ack)
                    req_addr_nxt = target;
                else
                    kill_nxt = 1'b1;
            end
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = req_addr;

endmodule

`default_nettype wire
